// File: rtl/fpu_fpl_mul_issue_if.sv
// Handshake and multiplier bus for fpu_fpl_mul_issue: request in, multiplier out/in, result out.
interface fpu_fpl_mul_issue_if #(
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_srca;
    logic [31:0]      in_srcb;
    logic [TAG_W-1:0] in_tag;
    logic             mul_enable;
    logic [31:0]      mul_srca;
    logic [31:0]      mul_srcb;
    logic [31:0]      mul_dst;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_flags;

    modport slave (
        input  in_valid, in_srca, in_srcb, in_tag, mul_dst, out_ready,
        output in_ready, mul_enable, mul_srca, mul_srcb, out_valid, out_data, out_tag, out_flags
    );

    modport master (
        output in_valid, in_srca, in_srcb, in_tag, mul_dst, out_ready,
        input  in_ready, mul_enable, mul_srca, mul_srcb, out_valid, out_data, out_tag, out_flags
    );
endinterface

// File: rtl/fpu_fpl_mul_issue.sv
// Issues one operand pair to an external combinational multiplier, holds it LAT cycles, returns
// the tagged result. Define FPU_FPL_SPECIAL_EN to bypass zero/infinity exponents at accept time.
module fpu_fpl_mul_issue #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned TAG_W = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    fpu_fpl_mul_issue_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    localparam logic [1:0] CntLoad = 2'(LAT - 1);

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [31:0]      srca_q, srca_d;
    logic [31:0]      srcb_q, srcb_d;
    logic [31:0]      data_q, data_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [1:0]       flags_q, flags_d;

    logic        in_ready;
    logic        accept;
    logic        byp_zero;
    logic        byp_inf;
    logic        bypass;
    logic [31:0] byp_data;

`ifdef FPU_FPL_SPECIAL_EN
    logic sgn;
    assign sgn      = bus.in_srca[31] ^ bus.in_srcb[31];
    // Zero exponent wins over an all-ones exponent on the other operand.
    assign byp_zero = (bus.in_srca[30:23] == 8'h00) || (bus.in_srcb[30:23] == 8'h00);
    assign byp_inf  = !byp_zero &&
                      ((bus.in_srca[30:23] == 8'hFF) || (bus.in_srcb[30:23] == 8'hFF));
    assign byp_data = {sgn, byp_inf ? 31'h7F80_0000 : 31'h0};
`else
    assign byp_zero = 1'b0;
    assign byp_inf  = 1'b0;
    assign byp_data = 32'h0;
`endif

    assign bypass = byp_zero | byp_inf;
    assign accept = bus.in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        srca_d  = srca_q;
        srcb_d  = srcb_q;
        data_d  = data_q;
        tag_d   = tag_q;
        flags_d = flags_q;
        case (state_q)
            StIssue: begin
                if (cnt_q == 2'd0) begin
                    state_d = StDone;
                    data_d  = bus.mul_dst;
                    flags_d = 2'b00;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: ;
        endcase
        // Accept only happens in idle or on a done handshake, so it overrides the above.
        if (accept) begin
            tag_d = bus.in_tag;
            if (bypass) begin
                state_d = StDone;
                data_d  = byp_data;
                flags_d = {byp_inf, byp_zero};
            end else begin
                state_d = StIssue;
                srca_d  = bus.in_srca;
                srcb_d  = bus.in_srcb;
                cnt_d   = CntLoad;
            end
        end
    end

    always_comb begin
        in_ready       = 1'b0;
        bus.mul_enable = 1'b0;
        bus.out_valid  = 1'b0;
        unique case (state_q)
            StIdle:  in_ready = 1'b1;
            StIssue: bus.mul_enable = 1'b1;
            StDone: begin
                bus.out_valid = 1'b1;
                in_ready      = bus.out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 2'd0;
            srca_q  <= 32'h0;
            srcb_q  <= 32'h0;
            data_q  <= 32'h0;
            tag_q   <= '0;
            flags_q <= 2'b00;
        end else begin
            cnt_q   <= cnt_d;
            srca_q  <= srca_d;
            srcb_q  <= srcb_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mul_srca  = srca_q;
    assign bus.mul_srcb  = srcb_q;
    assign bus.out_data  = data_q;
    assign bus.out_tag   = tag_q;
    assign bus.out_flags = flags_q;

endmodule

// File: tb/tb_fpu_fpl_mul_issue.sv
// Bench for fpu_fpl_mul_issue (LAT=2): transaction-timing model checked every cycle plus
// directed literal checks. Special-case vectors run when FPU_FPL_SPECIAL_EN is defined.
module tb_fpu_fpl_mul_issue;

    localparam int unsigned LAT   = 2;
    localparam int unsigned TAG_W = 4;

    logic        clk;
    logic        reset_n;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    fpu_fpl_mul_issue_if #(.TAG_W(TAG_W)) bus ();

    fpu_fpl_mul_issue #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in multiplier: true products for the directed pairs, a fixed hash otherwise.
    function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40000000_40400000: fake_mul = 32'h40C0_0000;
            64'h3FC00000_40000000: fake_mul = 32'h4040_0000;
            default:               fake_mul = a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
        endcase
    endfunction

    assign bus.mul_dst = fake_mul(bus.mul_srca, bus.mul_srcb);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: one outstanding request, result due a fixed number of edges after acceptance.
    logic             m_have;
    logic             m_byp;
    int unsigned      m_due;
    logic [31:0]      m_data, m_srca, m_srcb;
    logic [TAG_W-1:0] m_tag;
    logic [1:0]       m_flags;
    logic [1:0]       m_cls;
    logic             m_sgn;
    logic             m_valid, m_in_ready, m_en;

    assign m_sgn = bus.in_srca[31] ^ bus.in_srcb[31];
`ifdef FPU_FPL_SPECIAL_EN
    assign m_cls = (bus.in_srca[30:23] == 8'h00 || bus.in_srcb[30:23] == 8'h00) ? 2'd1 :
                   (bus.in_srca[30:23] == 8'hFF || bus.in_srcb[30:23] == 8'hFF) ? 2'd2 : 2'd0;
`else
    assign m_cls = 2'd0;
`endif
    assign m_valid    = m_have && (cyc >= m_due);
    assign m_in_ready = !m_have || (m_valid && bus.out_ready);
    assign m_en       = m_have && !m_byp && (cyc < m_due);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_have <= 1'b0;
            m_byp  <= 1'b0;
            m_due  <= 0;
            m_srca <= 32'h0;
            m_srcb <= 32'h0;
        end else if (bus.in_valid && m_in_ready) begin
            m_have  <= 1'b1;
            m_tag   <= bus.in_tag;
            m_byp   <= (m_cls != 2'd0);
            m_due   <= cyc + 1 + ((m_cls != 2'd0) ? 0 : LAT);
            m_flags <= m_cls;
            m_data  <= (m_cls == 2'd1) ? {m_sgn, 31'h0} :
                       (m_cls == 2'd2) ? {m_sgn, 8'hFF, 23'h0} :
                       fake_mul(bus.in_srca, bus.in_srcb);
            if (m_cls == 2'd0) begin
                m_srca <= bus.in_srca;
                m_srcb <= bus.in_srcb;
            end
        end else if (m_valid && bus.out_ready) begin
            m_have <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", {31'h0, bus.in_ready}, {31'h0, m_in_ready});
            chk("out_valid", {31'h0, bus.out_valid}, {31'h0, m_valid});
            chk("mul_enable", {31'h0, bus.mul_enable}, {31'h0, m_en});
            chk("mul_srca", bus.mul_srca, m_srca);
            chk("mul_srcb", bus.mul_srcb, m_srcb);
            if (m_valid) begin
                chk("out_data", bus.out_data, m_data);
                chk("out_tag", {28'h0, bus.out_tag}, {28'h0, m_tag});
                chk("out_flags", {30'h0, bus.out_flags}, {30'h0, m_flags});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Called 2 time units after a rising edge; returns at the same phase after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        output int unsigned acc);
        logic got;
        got = 1'b0;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_srca  = a;
        bus.in_srcb  = b;
        bus.in_tag   = t;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                step();
                acc = cyc;
                got = 1'b1;
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        if (!got) chk("send_accept_timeout", {31'h0, bus.in_ready}, 32'h1);
    endtask

    // Returns at the falling edge where out_valid is first seen high.
    task automatic wait_valid(output int unsigned vcyc, output int en_cnt);
        logic got;
        got    = 1'b0;
        vcyc   = 0;
        en_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mul_enable) en_cnt++;
            if (bus.out_valid) begin
                vcyc = cyc;
                got  = 1'b1;
                break;
            end
        end
        if (!got) chk("wait_valid_timeout", {31'h0, bus.out_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc, vc, rel;
        int          en;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_srca   = 32'h0;
        bus.in_srcb   = 32'h0;
        bus.in_tag    = 4'h0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_mul_enable", {31'h0, bus.mul_enable}, 32'h0);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("rst_mul_srca", bus.mul_srca, 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_tag", {28'h0, bus.out_tag}, 32'h0);
        chk("rst_out_flags", {30'h0, bus.out_flags}, 32'h0);
        reset_n = 1'b1;

        // 2.0 x 3.0, tag 3: two enable cycles, result two edges after accept.
        bus.out_ready = 1'b1;
        send(32'h4000_0000, 32'h4040_0000, 4'd3, acc);
        wait_valid(vc, en);
        chk("lat_2x3", vc - acc, 32'd2);
        chk("en_cycles_2x3", en, 32'd2);
        chk("data_2x3", bus.out_data, 32'h40C0_0000);
        chk("tag_2x3", {28'h0, bus.out_tag}, 32'd3);
        chk("flags_2x3", {30'h0, bus.out_flags}, 32'd0);
        step();

        // Stall the consumer: result and tag must hold, no new accept.
        bus.out_ready = 1'b0;
        send(32'h3FC0_0000, 32'h4000_0000, 4'd5, acc);
        wait_valid(vc, en);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'h0, bus.out_valid}, 32'h1);
            chk("hold_data", bus.out_data, 32'h4040_0000);
            chk("hold_tag", {28'h0, bus.out_tag}, 32'd5);
            chk("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
            step();
        end
        // Handshake and accept on the same edge, next result with no bubble.
        bus.out_ready = 1'b1;
        send(32'h1234_5678, 32'h9ABC_DEF0, 4'd7, acc);
        wait_valid(vc, en);
        chk("b2b_lat", vc - acc, 32'd2);
        chk("b2b_data", bus.out_data, 32'h1234_5678 ^ 32'hDEF0_9ABC ^ 32'h1234_5678);
        chk("b2b_tag", {28'h0, bus.out_tag}, 32'd7);
        step();

        // Back-to-back accepts while the consumer is always ready.
        send(32'h4000_0000, 32'h4040_0000, 4'd1, acc);
        wait_valid(vc, en);
        step();
        send(32'h0F0F_0F0F, 32'h4242_4242, 4'd2, acc);
        wait_valid(vc, en);

`ifdef FPU_FPL_SPECIAL_EN
        step();
        send(32'h8000_0000, 32'h3F80_0000, 4'd4, acc);
        @(negedge clk);
        chk("sz_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("sz_data", bus.out_data, 32'h8000_0000);
        chk("sz_flags", {30'h0, bus.out_flags}, 32'd1);
        chk("sz_mul_en", {31'h0, bus.mul_enable}, 32'h0);
        step();
        send(32'h7F80_0000, 32'h0000_0000, 4'd6, acc);
        @(negedge clk);
        chk("zi_data", bus.out_data, 32'h0000_0000);
        chk("zi_flags", {30'h0, bus.out_flags}, 32'd1);
        step();
        send(32'h7FC0_0000, 32'hBF80_0000, 4'd8, acc);
        @(negedge clk);
        chk("inf_data", bus.out_data, 32'hFF80_0000);
        chk("inf_flags", {30'h0, bus.out_flags}, 32'd2);
        chk("inf_srca_kept", bus.mul_srca, 32'h0F0F_0F0F);
`else
        step();
        send(32'h8000_0000, 32'h3F80_0000, 4'd4, acc);
        wait_valid(vc, en);
        chk("nosp_lat", vc - acc, 32'd2);
        chk("nosp_flags", {30'h0, bus.out_flags}, 32'd0);
`endif
        step();

        // Reset in the middle of an issue: outputs clear at once, the tag never appears.
        send(32'h3F80_0000, 32'h4120_0000, 4'd9, acc);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_mul_enable", {31'h0, bus.mul_enable}, 32'h0);
        chk("arst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("arst_mul_srca", bus.mul_srca, 32'h0);
        chk("arst_mul_srcb", bus.mul_srcb, 32'h0);
        chk("arst_out_tag", {28'h0, bus.out_tag}, 32'h0);
        chk("arst_out_data", bus.out_data, 32'h0);
        step();
        reset_n = 1'b1;
        rel = cyc;
        send(32'h4000_0000, 32'h4040_0000, 4'hA, acc);
        chk("post_rst_accept", acc - rel, 32'd1);
        wait_valid(vc, en);
        chk("post_rst_tag", {28'h0, bus.out_tag}, 32'hA);
        chk("post_rst_data", bus.out_data, 32'h40C0_0000);
        step();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
